// File: rtl/spi_frame_scheduler_pkg.sv
// Shared types and defaults for the SPI status-frame scheduler and its packer.
package spi_frame_scheduler_pkg;

  localparam int FRAME_W_DEF = 32;

  typedef enum logic [2:0] {IDLE, REQ, LOAD, SHIFT, GAP} spi_state_e;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// Control, packer and SPI pin bundle of the frame scheduler; master is the scheduler side.
interface spi_frame_scheduler_if
  import spi_frame_scheduler_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF
);

  logic               enable;
  logic               trig;
  logic [FRAME_W-1:0] data_frame;
  logic               req;
  logic               sclk;
  logic               mosi;
  logic               cs_n;
  logic               busy;
  logic               done;
  logic               overrun;

  modport master (
    input  enable, trig, data_frame,
    output req, sclk, mosi, cs_n, busy, done, overrun
  );

  modport slave (
    output enable, trig, data_frame,
    input  req, sclk, mosi, cs_n, busy, done, overrun
  );

endinterface

// File: rtl/spi_frame_scheduler_sclk_gen.sv
// SPI clock divider: toggles sclk every HALF_DIV cycles while run_i, flags rise/fall.
module spi_sclk_gen
  import spi_frame_scheduler_pkg::*;
#(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int              DIV_W    = cnt_w(HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic             tc;

  assign tc         = run_i && (div_cnt_q == DIV_LAST);
  assign rise_stb_o = tc && !sclk_q;
  assign fall_stb_o = tc && sclk_q;
  assign sclk_o     = sclk_q;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    if (start_i || !run_i) begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
    end else if (tc) begin
      div_cnt_d = '0;
      sclk_d    = !sclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Requests a frame from spi_packer on trigger and shifts it out as a mode-0 SPI master.
module spi_frame_scheduler
  import spi_frame_scheduler_pkg::*;
#(
  parameter int FRAME_W  = FRAME_W_DEF,
  parameter int HALF_DIV = 4,
  parameter int GAP_CYC  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_frame_scheduler_if.master bus
);

  localparam int               BIT_W    = $clog2(FRAME_W + 1);
  localparam int               GAP_W    = cnt_w(GAP_CYC);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  spi_state_e         state_q;
  logic               pending_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               req_q, cs_n_q, mosi_q, busy_q, done_q, overrun_q;

  logic trig_acc, sclk_start, sclk_run, sclk, rise_stb, fall_stb;

  assign trig_acc   = bus.enable && bus.trig;
  assign sclk_start = (state_q == LOAD);
  assign sclk_run   = (state_q == SHIFT);

  spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
    .clk        (clk),
    .reset      (reset),
    .start_i    (sclk_start),
    .run_i      (sclk_run),
    .sclk_o     (sclk),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      // NOTE: the shift register is reset too; it is small and keeps mosi deterministic.
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      req_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;

      // One trigger may wait behind the frame in flight; any further one is dropped.
      if (state_q != IDLE && trig_acc) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (trig_acc || pending_q) begin
            state_q   <= REQ;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        REQ: state_q <= LOAD;
        LOAD: begin
          shreg_q   <= bus.data_frame;
          mosi_q    <= bus.data_frame[FRAME_W-1];
          cs_n_q    <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (rise_stb) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end else if (fall_stb) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q   <= GAP;
              cs_n_q    <= 1'b1;
              mosi_q    <= 1'b0;
              done_q    <= 1'b1;
              gap_cnt_q <= '0;
            end else begin
              shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
              mosi_q  <= shreg_q[FRAME_W-2];
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req     = req_q;
  assign bus.sclk    = sclk;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed/randomized bench for spi_frame_scheduler with a modelled spi_packer and SPI receiver.
module tb_spi_frame_scheduler;

  localparam int FW = 32;
  localparam int HD = 2;
  localparam int GC = 4;
  localparam int CS_LOW = FW * 2 * HD;

  logic clk;
  logic reset;

  spi_frame_scheduler_if #(.FRAME_W(FW)) bus ();

  spi_frame_scheduler #(.FRAME_W(FW), .HALF_DIV(HD), .GAP_CYC(GC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Packer model and expected-frame queue.
  logic [FW-1:0] frame_vals [16];
  int            fv_idx = 0;
  logic [FW-1:0] exp_q [$];

  // Receiver-side observations.
  int            cyc = 0;
  int            req_cnt = 0, done_cnt = 0, ovr_cnt = 0, frames_done = 0;
  int            last_req_cyc = -1, last_done_cyc = -1, cs_fall_cyc = -1, busy_fall_cyc = -1;
  int            rise_cnt = 0, low_len = 0;
  logic [FW-1:0] rx_word = '0;
  logic          prev_cs_n = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: packer captures on req, then the SPI lines are observed 1ns after the edge.
  task automatic tick();
    logic          req_pre;
    logic [FW-1:0] exp_word;
    req_pre = bus.req;
    @(posedge clk);
    #1;
    cyc++;
    if (req_pre) begin
      bus.data_frame = frame_vals[fv_idx % 16];
      exp_q.push_back(frame_vals[fv_idx % 16]);
      fv_idx++;
    end else begin
      bus.data_frame = $urandom();
    end
    if (!reset) begin
      prev_cs_n = 1'b1;
      prev_sclk = 1'b0;
      prev_busy = 1'b0;
      return;
    end
    if (bus.req)     begin req_cnt++;  last_req_cyc  = cyc; end
    if (bus.done)    begin done_cnt++; last_done_cyc = cyc; end
    if (bus.overrun) ovr_cnt++;
    if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
    if (prev_cs_n && !bus.cs_n) begin
      cs_fall_cyc = cyc;
      rx_word     = '0;
      rise_cnt    = 0;
      low_len     = 0;
    end
    if (!bus.cs_n) begin
      low_len++;
      if (!prev_sclk && bus.sclk) begin
        rx_word = {rx_word[FW-2:0], bus.mosi};
        rise_cnt++;
      end
    end
    if (!prev_cs_n && bus.cs_n) begin
      frames_done++;
      check("done_at_cs_rise", 64'(bus.done), 64'd1);
      check("sclk_rises", 64'(rise_cnt), 64'(FW));
      check("cs_low_cycles", 64'(low_len), 64'(CS_LOW));
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_word = exp_q.pop_front();
        check("frame_word", 64'(rx_word), 64'(exp_word));
      end
    end
    prev_cs_n = bus.cs_n;
    prev_sclk = bus.sclk;
    prev_busy = bus.busy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Trigger is high for the cycle numbered t; the DUT samples it at the following edge.
  task automatic pulse_trig(output int t);
    t = cyc;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
  endtask

  initial begin
    int t, t_dummy, rc0, dc0, fd0, oc0, a, b;

    frame_vals[0] = 32'hA5C3_0F01;
    for (int i = 1; i < 16; i++) frame_vals[i] = $urandom();
    bus.enable     = 1'b1;
    bus.trig       = 1'b0;
    bus.data_frame = '0;
    reset          = 1'b0;

    // 1: reset state, then quiet without triggers
    run(3);
    check("rst_cs_n", 64'(bus.cs_n), 64'd1);
    check("rst_sclk", 64'(bus.sclk), 64'd0);
    check("rst_req", 64'(bus.req), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mosi_done_ovr", {61'd0, bus.mosi, bus.done, bus.overrun}, 64'd0);
    reset = 1'b1;
    run(20);
    check("idle_no_req", 64'(req_cnt), 64'd0);
    check("idle_cs_n", 64'(bus.cs_n), 64'd1);

    // 2: single frame A5C30F01 with exact timing
    rc0 = req_cnt; dc0 = done_cnt; fd0 = frames_done;
    pulse_trig(t);
    run(140);
    check("s_req_cnt", 64'(req_cnt - rc0), 64'd1);
    check("s_req_cyc", 64'(last_req_cyc), 64'(t + 1));
    check("s_cs_fall_cyc", 64'(cs_fall_cyc), 64'(t + 3));
    check("s_done_cnt", 64'(done_cnt - dc0), 64'd1);
    check("s_done_cyc", 64'(last_done_cyc), 64'(t + 3 + CS_LOW));
    check("s_frames", 64'(frames_done - fd0), 64'd1);
    check("s_busy_fall", 64'(busy_fall_cyc - last_done_cyc), 64'(GC));

    // 3: trigger during SHIFT becomes pending, served on first IDLE cycle after GAP
    rc0 = req_cnt; fd0 = frames_done; oc0 = ovr_cnt;
    pulse_trig(t);
    run(39);
    pulse_trig(t_dummy);
    run(300);
    check("p_req_cnt", 64'(req_cnt - rc0), 64'd2);
    check("p_req2_cyc", 64'(last_req_cyc), 64'(t + 3 + CS_LOW + GC + 1));
    check("p_done2_cyc", 64'(last_done_cyc), 64'(t + 3 + CS_LOW + GC + 1 + 2 + CS_LOW));
    check("p_frames", 64'(frames_done - fd0), 64'd2);
    check("p_no_ovr", 64'(ovr_cnt - oc0), 64'd0);

    // 4: two extra triggers at random points in one frame
    rc0 = req_cnt; fd0 = frames_done; oc0 = ovr_cnt;
    a = $urandom_range(3, 40);
    b = $urandom_range(10, 60);
    pulse_trig(t);
    run(a);
    pulse_trig(t_dummy);
    run(b);
    pulse_trig(t_dummy);
    run(320);
    check("o_ovr_cnt", 64'(ovr_cnt - oc0), 64'd1);
    check("o_req_cnt", 64'(req_cnt - rc0), 64'd2);
    check("o_frames", 64'(frames_done - fd0), 64'd2);
    check("o_req2_cyc", 64'(last_req_cyc), 64'(t + 3 + CS_LOW + GC + 1));

    // 5: reset at bit 10 aborts immediately; next frame is complete
    dc0 = done_cnt; fd0 = frames_done;
    pulse_trig(t);
    run(2 + 2 * HD * 10 - HD);
    check("a_rise_at_abort", 64'(rise_cnt), 64'd10);
    reset = 1'b0;
    #1;
    check("a_cs_n", 64'(bus.cs_n), 64'd1);
    check("a_sclk", 64'(bus.sclk), 64'd0);
    check("a_busy", 64'(bus.busy), 64'd0);
    exp_q.delete();
    run(3);
    reset = 1'b1;
    run(10);
    check("a_no_done", 64'(done_cnt - dc0), 64'd0);
    check("a_no_frame", 64'(frames_done - fd0), 64'd0);
    pulse_trig(t);
    run(140);
    check("a_fresh_frames", 64'(frames_done - fd0), 64'd1);
    check("a_fresh_done_cyc", 64'(last_done_cyc), 64'(t + 3 + CS_LOW));

    // 6: enable=0 ignores triggers, frames in flight and pending ones still complete
    rc0 = req_cnt; oc0 = ovr_cnt; fd0 = frames_done;
    bus.enable = 1'b0;
    pulse_trig(t_dummy);
    run(20);
    check("e_no_req", 64'(req_cnt - rc0), 64'd0);
    check("e_idle_busy", 64'(bus.busy), 64'd0);
    bus.enable = 1'b1;
    pulse_trig(t);
    run(10);
    bus.enable = 1'b0;
    run(10);
    pulse_trig(t_dummy);
    run(150);
    check("e_req_cnt", 64'(req_cnt - rc0), 64'd1);
    check("e_frames", 64'(frames_done - fd0), 64'd1);
    check("e_no_ovr", 64'(ovr_cnt - oc0), 64'd0);
    check("e_done_cyc", 64'(last_done_cyc), 64'(t + 3 + CS_LOW));

    rc0 = req_cnt; fd0 = frames_done;
    bus.enable = 1'b1;
    pulse_trig(t);
    run(20);
    pulse_trig(t_dummy);
    run(5);
    bus.enable = 1'b0;
    run(300);
    check("e_pend_req_cnt", 64'(req_cnt - rc0), 64'd2);
    check("e_pend_frames", 64'(frames_done - fd0), 64'd2);
    check("e_pend_req_cyc", 64'(last_req_cyc), 64'(t + 3 + CS_LOW + GC + 1));
    bus.enable = 1'b1;
    run(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
